h264_frame_sched: RTL and testbench
===================================

# h264_frame_sched

Sequencer that drives the H264 encoder core through a full frame, one macroblock at a time. It sits between a YUV word source, such as a DMA read stream, and the H264 core. For each macroblock it clears the core's output buffer, feeds exactly one macroblock of words under the core's `fetch_req` flow control, then drains the compressed words into a result stream. It raises a level interrupt when the whole frame is done, so the CPU no longer polls `h264_buf_cnt` over AXI.

## Interface
Parameters:
- `MB_WORDS`, 96: 32-bit words per macroblock (4:2:0, 8-bit samples); valid range 1..255.
- `MB_CNT_W`, 12: width of the macroblock counter.
- `TIMEOUT_CYC`, 4096: watchdog limit in cycles; used only with `H264_SCHED_TIMEOUT_EN`.

Ports (all outputs registered unless marked combinational):
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous reset, active-low.
- `start`, in, 1: 1-cycle pulse; ignored unless the state is IDLE or DONE.
- `cfg_num_mb`, in, MB_CNT_W: macroblocks per frame; sampled on `start`; 0 means go straight to DONE.
- `irq_clr`, in, 1: clears `irq`.
- `busy`, out, 1: high whenever the state is not IDLE or DONE.
- `irq`, out, 1: frame complete; sticky.
- `err`, out, 2: bit0 = buffer overflow (`h264_buf_cnt` > 256); bit1 = timeout.
- `src_valid`, in, 1: source word valid.
- `src_data`, in, 32: source word.
- `src_ready`, out, 1, combinational: accept handshake to the source.
- `h264_en`, out, 1: core enable.
- `h264_buf_clear`, out, 1: core buffer-clear pulse.
- `data_valid`, out, 1, combinational: word strobe to the core.
- `data_word`, out, 32, combinational: word to the core.
- `fetch_req`, in, 1: core can accept a word.
- `h264_addr`, out, 8: result read address.
- `h264_out`, in, 32: result word; valid 1 cycle after `h264_addr`.
- `h264_buf_cnt`, in, 32: number of result words in the core buffer.
- `res_valid`, out, 1: result stream valid.
- `res_data`, out, 32: result stream data.
- `res_last`, out, 1: last word of the frame.
- `res_ready`, in, 1: result stream ready.

## Operation
States: IDLE, CLEAR, FEED, WAIT_OUT, RD_ADDR, RD_HOLD, DONE.

- **IDLE/DONE → CLEAR**: on `start` when `cfg_num_mb` != 0. Latches `cfg_num_mb`, zeroes `mb_cnt` and `err`, drops `irq`.
- **IDLE/DONE → DONE**: on `start` when `cfg_num_mb` == 0. Sets `irq`.
- **CLEAR**: asserts `h264_buf_clear` for exactly 1 cycle, zeroes `feed_cnt`, then goes to FEED. `h264_en` is high from CLEAR through the last DRAIN of the frame.
- **FEED**:
  - `src_ready` = FEED && `fetch_req` && `feed_cnt` < MB_WORDS.
  - `data_valid` = `src_valid` && `src_ready`.
  - `data_word` = `src_data` when `data_valid` is high, else 0.
  - `feed_cnt` increments on each `data_valid`.
  - When `feed_cnt` reaches MB_WORDS, go to WAIT_OUT.
- **WAIT_OUT**: waits for `fetch_req` high with `h264_buf_cnt` != 0, then latches `drain_n` = min(`h264_buf_cnt`, 256). A value above 256 sets `err[0]`. Zeroes `h264_addr` and goes to RD_ADDR.
- **RD_ADDR**: 1 cycle with `h264_addr` presented, then goes to RD_HOLD and loads `res_data` from `h264_out` on entry.
- **RD_HOLD**: holds `res_valid` high until `res_ready`. On handshake, increments `h264_addr`:
  - If more words remain for this macroblock, go to RD_ADDR.
  - Else increment `mb_cnt`. If `mb_cnt` + 1 == `cfg_num_mb`, go to DONE and set `irq`; otherwise go to CLEAR.
- `res_last` is high only on the final word of the final macroblock.
- **`irq`**: cleared by `irq_clr` or by an accepted `start`. If `irq_clr` and the set condition coincide, the set wins.
- **Mid-frame `start`**: ignored. There is no abort; only reset aborts a frame.

## Timing
- Reset values: state IDLE; `busy`, `irq`, `err`, `h264_en`, `h264_buf_clear`, `res_valid`, `res_last` = 0; `h264_addr`, `res_data` = 0. Combinational outputs are 0 in IDLE.
- `start` → `h264_buf_clear` pulse: 1 cycle. CLEAR → first possible feed: 1 cycle.
- Feed throughput: 1 word/cycle while both `fetch_req` and `src_valid` are high. There is no internal buffering; a low `fetch_req` stalls the source in the same cycle.
- Drain throughput: 1 word per 2 cycles with `res_ready` tied high. `res_data` and `res_last` are stable while `res_valid && !res_ready`.
- Reset asserted mid-frame returns every register to its reset value immediately (asynchronous). The core is not cleared until the next CLEAR.

## Configuration
- **`H264_SCHED_TIMEOUT_EN` defined**:
  - A watchdog counts cycles spent in WAIT_OUT.
  - Reaching TIMEOUT_CYC sets `err[1]`, deasserts `h264_en`, and goes to DONE with `irq` set. No results are emitted for that macroblock.
  - The counter resets on every entry to WAIT_OUT.
- **Undefined**: WAIT_OUT waits indefinitely and `err[1]` is tied to 0.

## Structure
- Shared package `h264_sched_pkg`: state enum `sched_state_e`, default `MB_WORDS`, `DRAIN_MAX` = 256, error bit indices `ERR_OVF` = 0 and `ERR_TMO` = 1.
- No sub-module is required. If the watchdog is added, it is natural as `sched_watchdog` (counter, clear, expire pulse).

## Test plan
- MB_WORDS=4, `cfg_num_mb`=2, `fetch_req` and `src_valid` held high, `h264_buf_cnt`=3 → one clear pulse per macroblock, 4 `data_valid` per macroblock, 6 result words with `res_last` on the 6th, `irq`=1, `busy`=0.
- Toggle `fetch_req` 1-0 during FEED → `src_ready` and `data_valid` are never high while `fetch_req`=0, and exactly MB_WORDS words are accepted.
- `h264_buf_cnt`=300 → `err[0]`=1, exactly 256 words drained, `h264_addr` ends at 255.
- `res_ready` low for 5 cycles mid-drain → `res_data` is held and no word is lost or duplicated.
- `start` with `cfg_num_mb`=0 → DONE and `irq` in 1 cycle with no `h264_buf_clear`. Then `irq_clr` → `irq`=0.
- With `H264_SCHED_TIMEOUT_EN` and TIMEOUT_CYC=16, `h264_buf_cnt` held at 0 → `err[1]`=1 after 16 WAIT_OUT cycles, `h264_en`=0, `irq`=1. Reset asserted mid-FEED → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/h264_sched_pkg.sv
// Shared types and constants for the H264 frame scheduler.
package h264_sched_pkg;

    localparam int unsigned MB_WORDS_DFLT = 96;
    localparam int unsigned DRAIN_MAX     = 256;
    localparam int unsigned ERR_OVF       = 0;
    localparam int unsigned ERR_TMO       = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT_OUT,
        RD_ADDR,
        RD_HOLD,
        DONE
    } sched_state_e;

    // True while a frame is in flight.
    function automatic logic is_active(sched_state_e s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/h264_frame_sched.sv
// Per-macroblock sequencer for the H264 core: clear, feed, drain, interrupt.
// Optional WAIT_OUT watchdog enabled by defining H264_SCHED_TIMEOUT_EN.
module h264_frame_sched
    import h264_sched_pkg::*;
#(
    parameter int unsigned MB_WORDS    = MB_WORDS_DFLT,
    parameter int unsigned MB_CNT_W    = 12,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MB_CNT_W-1:0] cfg_num_mb,
    input  logic                irq_clr,
    output logic                busy,
    output logic                irq,
    output logic [1:0]          err,
    input  logic                src_valid,
    input  logic [31:0]         src_data,
    output logic                src_ready,
    output logic                h264_en,
    output logic                h264_buf_clear,
    output logic                data_valid,
    output logic [31:0]         data_word,
    input  logic                fetch_req,
    output logic [7:0]          h264_addr,
    input  logic [31:0]         h264_out,
    input  logic [31:0]         h264_buf_cnt,
    output logic                res_valid,
    output logic [31:0]         res_data,
    output logic                res_last,
    input  logic                res_ready
);

    localparam int unsigned FEED_W = 8;
    localparam int unsigned DRN_W  = 9;

    sched_state_e        state, state_nxt;
    logic [FEED_W-1:0]   feed_cnt;
    logic [DRN_W-1:0]    drain_n;
    logic [MB_CNT_W-1:0] mb_cnt, num_mb;
    logic                start_ok, start_run, drain_go, hs, more_words, last_mb;
    logic                tmo_hit, irq_set;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign start_run  = start_ok && (cfg_num_mb != '0);
    assign drain_go   = (state == WAIT_OUT) && fetch_req && (h264_buf_cnt != 32'd0);
    assign hs         = (state == RD_HOLD) && res_ready;
    assign more_words = (DRN_W'(h264_addr) + DRN_W'(1)) < drain_n;
    assign last_mb    = (mb_cnt + MB_CNT_W'(1)) == num_mb;
    assign irq_set    = (start_ok && cfg_num_mb == '0) || (hs && !more_words && last_mb) || tmo_hit;

`ifdef H264_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Counts cycles spent in WAIT_OUT; restarts from zero on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state != WAIT_OUT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign tmo_hit = (state == WAIT_OUT) && !drain_go && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYC);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = (cfg_num_mb == '0) ? DONE : CLEAR;
            CLEAR:      state_nxt = FEED;
            FEED:       if (data_valid && feed_cnt == FEED_W'(MB_WORDS - 1)) state_nxt = WAIT_OUT;
            WAIT_OUT: begin
                if (drain_go) begin
                    state_nxt = RD_ADDR;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            RD_ADDR:    state_nxt = RD_HOLD;
            RD_HOLD: begin
                if (res_ready) begin
                    if (more_words) begin
                        state_nxt = RD_ADDR;
                    end else begin
                        state_nxt = last_mb ? DONE : CLEAR;
                    end
                end
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Source-to-core path is pass-through; fetch_req stalls the source in the same cycle.
    always_comb begin
        src_ready  = 1'b0;
        data_valid = 1'b0;
        data_word  = '0;
        src_ready  = (state == FEED) && fetch_req && (feed_cnt < FEED_W'(MB_WORDS));
        data_valid = src_valid && src_ready;
        if (data_valid) begin
            data_word = src_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy           <= 1'b0;
            h264_en        <= 1'b0;
            h264_buf_clear <= 1'b0;
            irq            <= 1'b0;
            err            <= '0;
            num_mb         <= '0;
            mb_cnt         <= '0;
            feed_cnt       <= '0;
            drain_n        <= '0;
            h264_addr      <= '0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            res_last       <= 1'b0;
        end else begin
            busy           <= is_active(state_nxt);
            h264_en        <= is_active(state_nxt);
            h264_buf_clear <= (state_nxt == CLEAR);

            if (start_run) begin
                num_mb <= cfg_num_mb;
                mb_cnt <= '0;
                err    <= '0;
            end

            if (state == CLEAR) begin
                feed_cnt <= '0;
            end else if (data_valid) begin
                feed_cnt <= feed_cnt + 8'd1;
            end

            // Drain length is capped at the core buffer depth; excess flags overflow.
            if (drain_go) begin
                drain_n   <= (h264_buf_cnt > 32'(DRAIN_MAX)) ? DRN_W'(DRAIN_MAX) : h264_buf_cnt[DRN_W-1:0];
                h264_addr <= '0;
                if (h264_buf_cnt > 32'(DRAIN_MAX)) begin
                    err[ERR_OVF] <= 1'b1;
                end
            end
            if (tmo_hit) begin
                err[ERR_TMO] <= 1'b1;
            end

            if (state == RD_ADDR) begin
                res_valid <= 1'b1;
                res_data  <= h264_out;
                res_last  <= !more_words && last_mb;
            end
            // Address stays on the final word so it reads back as drain_n - 1.
            if (hs) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
                if (more_words) begin
                    h264_addr <= h264_addr + 8'd1;
                end else begin
                    mb_cnt <= mb_cnt + MB_CNT_W'(1);
                end
            end

            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr || start_run) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_h264_frame_sched.sv
// Directed self-checking bench for h264_frame_sched (MB_WORDS=4, TIMEOUT_CYC=16).
`timescale 1ns/1ps
module tb_h264_frame_sched;

    localparam int unsigned MBW = 4;
    localparam int unsigned CW  = 12;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst, start, irq_clr, src_valid, fetch_req, res_ready;
    logic [CW-1:0] cfg_num_mb;
    logic [31:0]   src_data, h264_out, h264_buf_cnt, data_word, res_data;
    logic          busy, irq, src_ready, h264_en, h264_buf_clear, data_valid, res_valid, res_last;
    logic [1:0]    err;
    logic [7:0]    h264_addr;

    int n_cmp = 0;
    int n_bad = 0;

    int          src_idx = 0;
    logic [7:0]  core_tag = 8'd0;
    int          n_clr = 0, fr_bad = 0, hold_bad = 0, stall_seen = 0;
    logic [31:0] fed_q[$];
    logic [31:0] res_q[$];
    bit          last_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    h264_frame_sched #(.MB_WORDS(MBW), .MB_CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_mb(cfg_num_mb), .irq_clr(irq_clr),
        .busy(busy), .irq(irq), .err(err),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .h264_en(h264_en), .h264_buf_clear(h264_buf_clear),
        .data_valid(data_valid), .data_word(data_word), .fetch_req(fetch_req),
        .h264_addr(h264_addr), .h264_out(h264_out), .h264_buf_cnt(h264_buf_cnt),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Source is a counting stream; core result word encodes clear count and address.
    assign src_data = 32'h5000_0000 + 32'(src_idx);
    assign h264_out = {core_tag, 16'h0000, h264_addr};

    always @(posedge clk) begin
        if (data_valid) src_idx <= src_idx + 1;
        if (h264_buf_clear) core_tag <= core_tag + 8'd1;
    end

    always @(negedge clk) begin
        if (h264_buf_clear) n_clr++;
        if (src_ready && !fetch_req) fr_bad++;
        if (data_valid) fed_q.push_back(data_word);
        if (prev_stall) begin
            stall_seen++;
            if (!res_valid || res_data !== prev_data || res_last !== prev_last) hold_bad++;
        end
        if (res_valid && res_ready) begin
            res_q.push_back(res_data);
            last_q.push_back(res_last);
        end
        prev_stall = res_valid && !res_ready;
        prev_data  = res_data;
        prev_last  = res_last;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [CW-1:0] n);
        cfg_num_mb = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_flags"}, 32'({busy, irq, err, h264_en, h264_buf_clear, res_valid, res_last,
                                    src_ready, data_valid}), 32'd0);
        check({tag, "_addr"}, 32'(h264_addr), 32'd0);
        check({tag, "_res_data"}, res_data, 32'd0);
        check({tag, "_data_word"}, data_word, 32'd0);
    endtask

    task automatic run_to_irq(input int budget, input bit toggle_fr, input int stall_after,
                              output int cycles);
        int stall_left = 5;
        int base = res_q.size();
        cycles = 0;
        while (!irq && cycles < budget) begin
            if (toggle_fr) fetch_req = ~fetch_req;
            if (stall_after >= 0 && res_q.size() - base == stall_after && res_valid && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = 1'b1;
            end
            tick();
            cycles++;
        end
        res_ready = 1'b1;
        check("irq_within_budget", 32'(irq), 32'd1);
    endtask

    task automatic check_fed(input int fed0, input int n);
        check("fed_count", 32'(fed_q.size() - fed0), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (fed0 + i < fed_q.size()) check("fed_word", fed_q[fed0 + i], 32'h5000_0000 + 32'(fed0 + i));
        end
    endtask

    task automatic check_res(input int res0, input int clr0, input int n_mb, input int per_mb);
        int total = n_mb * per_mb;
        check("res_count", 32'(res_q.size() - res0), 32'(total));
        for (int m = 0; m < n_mb; m++) begin
            for (int a = 0; a < per_mb; a++) begin
                int k = res0 + m * per_mb + a;
                if (k < res_q.size()) begin
                    check("res_data", res_q[k], {8'(clr0 + m + 1), 16'h0000, 8'(a)});
                    check("res_last", 32'(last_q[k]), 32'(m * per_mb + a == total - 1));
                end
            end
        end
    endtask

    initial begin
        int clr0, fed0, res0, fr0, hb0, st0, cyc;

        rst = 1'b0; start = 1'b0; irq_clr = 1'b0; cfg_num_mb = '0;
        src_valid = 1'b1; fetch_req = 1'b1; res_ready = 1'b1; h264_buf_cnt = 32'd3;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_idle_outs("reset");

        // Two macroblocks, free-flowing, with an ignored mid-frame start.
        clr0 = n_clr; fed0 = fed_q.size(); res0 = res_q.size(); fr0 = fr_bad;
        pulse_start(12'd2);
        check("clear_pulse", 32'(h264_buf_clear), 32'd1);
        check("busy_on", 32'(busy), 32'd1);
        check("en_on", 32'(h264_en), 32'd1);
        tick();
        check("clear_width", 32'(h264_buf_clear), 32'd0);
        check("feed_ready", 32'(src_ready), 32'd1);
        cfg_num_mb = 12'd0; start = 1'b1;
        tick();
        start = 1'b0;
        run_to_irq(200, 1'b0, -1, cyc);
        check("t1_clears", 32'(n_clr - clr0), 32'd2);
        check_fed(fed0, 8);
        check_res(res0, clr0, 2, 3);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_en", 32'(h264_en), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_fr", 32'(fr_bad - fr0), 32'd0);

        // fetch_req toggling while feeding.
        h264_buf_cnt = 32'd2; fetch_req = 1'b1;
        clr0 = n_clr; fed0 = fed_q.size(); res0 = res_q.size(); fr0 = fr_bad;
        pulse_start(12'd1);
        check("t2_irq_dropped", 32'(irq), 32'd0);
        run_to_irq(200, 1'b1, -1, cyc);
        check("t2_fr_gated", 32'(fr_bad - fr0), 32'd0);
        check_fed(fed0, MBW);
        check_res(res0, clr0, 1, 2);

        // Buffer count above the drain cap.
        h264_buf_cnt = 32'd300; fetch_req = 1'b1;
        clr0 = n_clr; res0 = res_q.size();
        pulse_start(12'd1);
        run_to_irq(2000, 1'b0, -1, cyc);
        check("t3_err_ovf", 32'(err), 32'd1);
        check("t3_addr_end", 32'(h264_addr), 32'd255);
        check_res(res0, clr0, 1, 256);

        // Result backpressure for 5 cycles mid-drain.
        h264_buf_cnt = 32'd5;
        clr0 = n_clr; res0 = res_q.size(); hb0 = hold_bad; st0 = stall_seen;
        pulse_start(12'd1);
        check("t4_err_cleared", 32'(err), 32'd0);
        run_to_irq(200, 1'b0, 2, cyc);
        check("t4_hold", 32'(hold_bad - hb0), 32'd0);
        check("t4_stalls", 32'(stall_seen - st0), 32'd5);
        check_res(res0, clr0, 1, 5);

        // Zero-macroblock frame and irq_clr.
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t5_irq_clr", 32'(irq), 32'd0);
        clr0 = n_clr;
        pulse_start(12'd0);
        check("t5_irq", 32'(irq), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        check("t5_no_clear", 32'(n_clr - clr0), 32'd0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t5_irq_clr2", 32'(irq), 32'd0);

        // Asynchronous reset while stalled in FEED.
        fetch_req = 1'b0; h264_buf_cnt = 32'd3;
        pulse_start(12'd1);
        tick();
        tick();
        fetch_req = 1'b1;
        #1;
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_ready_pre", 32'(src_ready), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_idle_outs("t6_async");
        tick();
        rst = 1'b1;
        tick();

`ifdef H264_SCHED_TIMEOUT_EN
        // Watchdog: core never reports results.
        h264_buf_cnt = 32'd0; fetch_req = 1'b1;
        res0 = res_q.size();
        pulse_start(12'd1);
        run_to_irq(200, 1'b0, -1, cyc);
        check("t7_latency", 32'(cyc), 32'd21);
        check("t7_err_tmo", 32'(err), 32'd2);
        check("t7_en", 32'(h264_en), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_no_res", 32'(res_q.size() - res0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
